layer_stream_ctrl: RTL and testbench
====================================

Name: layer_stream_ctrl

Overview:
- Sequences one fully connected layer's results into the next layer.
- Captures each producing neuron's output on that neuron's outvalid pulse into a ping-pong frame buffer.
- Once a frame is complete, replays it as one contiguous myinput/myinputValid burst of exactly numNeurons words to every neuron of the next layer.
- Enforces the inter-burst idle gap the consuming neurons need to detect end-of-burst and apply bias.

Parameters:
- numNeurons, 30: neurons in the producing layer; equals the next layer's numWeight.
- dataWidth, 16: width of one activation word.
- gapCycles, 2: minimum idle cycles between bursts (≥1).

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- in_data, input, numNeurons*dataWidth: neuron outputs; word i at bits [i*dataWidth +: dataWidth].
- in_valid, input, numNeurons: per-neuron outvalid pulses.
- out_data, output, dataWidth: word to the next layer's myinput.
- out_valid, output, 1: drives the next layer's myinputValid.
- frame_done, output, 1: one-cycle pulse in the cycle after the last word of a burst.
- busy, output, 1: high whenever a bank holds a complete frame or a burst/gap is in progress.
- overrun, output, 1: sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, frame_done=0, busy=0, overrun=0.
  - Both bank masks cleared, capture bank = 0, state IDLE, gap counter = 0.
  - A burst in progress aborts immediately; the next layer must also be reset.
- Storage: two banks of numNeurons×dataWidth registers plus a numNeurons-bit capture mask per bank.
- Capture:
  - At each edge, for every i with in_valid[i]=1, in_data word i is written to slot i of the capture bank and mask bit i is set.
  - If mask bit i is already set, the write is dropped, the stored value is kept and overrun is set.
  - overrun clears only on reset.
- Frame complete: capture-bank mask all ones.
- Swap: taken at an edge where the capture bank is complete and the state is IDLE.
  - Stream bank ← capture bank; capture bank index toggles.
  - The new capture bank's mask clears, except that in_valid bits sampled at that same edge are written into the new capture bank.
  - The state goes to STREAM and the word index goes to 0.
- States:
  - IDLE: out_valid=0. Swap when the capture bank is complete; otherwise stay.
  - STREAM: out_valid=1, out_data = stream bank word[idx].
    - idx increments every cycle with no stall and no bubble.
    - At idx=numNeurons-1, the next edge goes to GAP (or to IDLE directly if gapCycles would be 0, which is not permitted), pulses frame_done for one cycle and loads the gap counter with gapCycles-1.
  - GAP: out_valid=0. The counter decrements; at 0 the next edge goes to IDLE.
    - A complete capture bank waits during GAP; the swap occurs at the first edge in IDLE.
- Timing:
  - Final in_valid sampled at edge E with state IDLE → swap at edge E+1.
  - out_valid high from after E+1 through E+numNeurons+1; out_valid falls and frame_done pulses at E+numNeurons+1.
  - Minimum out_valid low time between bursts = gapCycles+1 cycles (GAP plus the IDLE swap cycle).
- Burst: always exactly numNeurons consecutive high cycles; word order is neuron index 0 first.
- Back-pressure: none. When both banks are full (one streaming, one complete), further pulses to the complete bank are overruns.
- Arithmetic: data is passed through unmodified; the word index is $clog2(numNeurons+1) bits wide.
- out_data is registered and holds its last value when out_valid=0.
- busy = state≠IDLE, OR the capture bank is complete.

Test Plan:
- Reset, then all 30 in_valid bits high in one cycle with word i = 16'h0100+i → out_valid high for exactly 30 cycles starting 2 edges later.
  - out_data sequence 0x0100..0x011D; frame_done pulses once; out_valid then low for ≥3 cycles.
- in_valid bits pulsed one per cycle in descending index order 29..0 → after neuron 0's pulse, the burst still emits index order 0..29 with correct values.
- Second complete frame (words 16'hA000+i) arrives during the first burst → it streams exactly gapCycles+1 low cycles after the first burst ends, with no word corruption.
- Neuron 5 pulses twice (values 0x1111 then 0x2222) before its frame completes → overrun=1 and stays high; the burst emits 0x1111 at index 5.
- Assert rst low at burst index 12 → out_valid, busy and frame_done drop immediately.
  - After release, a fresh frame streams from index 0 with no leftover data.
- Frame completes on the same edge as a swap, with in_valid[3] high → the index-3 value lands in the new capture bank, its mask bit is preset and no overrun is flagged.

Source files
------------

// File: rtl/layer_stream_ctrl.sv
// layer_stream_ctrl: ping-pong frame buffer between two fully connected layers.
// Producing neurons drop their results into the capture bank on their own
// outvalid pulses. A complete frame is swapped into the stream bank and
// replayed as one contiguous burst of numNeurons words, followed by an idle gap.
//
// Handshake: out_valid is a pure valid with no ready. Every cycle it is high,
// out_data carries one word that the consumer must take. Bursts never stall.
// out_data keeps its last value while out_valid is low.
module layer_stream_ctrl #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int gapCycles  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [numNeurons*dataWidth-1:0]  in_data,
  input  logic [numNeurons-1:0]            in_valid,
  output logic [dataWidth-1:0]             out_data,
  output logic                             out_valid,
  output logic                             frame_done,
  output logic                             busy,
  output logic                             overrun,
  output logic [1:0]                       state_dbg
);

  localparam int IW = $clog2(numNeurons + 1);
  localparam int AW = $clog2(numNeurons);
  localparam int GW = (gapCycles > 1) ? $clog2(gapCycles) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(numNeurons - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(gapCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   cap_sel_q;
  logic [numNeurons-1:0]  mask_q [2];
  logic [dataWidth-1:0]   bank_q [2][numNeurons];
  logic [dataWidth-1:0]   out_data_d;
  logic                   frame_done_d;
  logic                   swap;
  logic                   cap_complete;
  logic                   wr_sel;
  logic [numNeurons-1:0]  cap_mask;
  logic [numNeurons-1:0]  wr_en;

  assign cap_mask     = mask_q[cap_sel_q];
  assign cap_complete = &cap_mask;

  // At a swap the incoming pulses belong to the bank that is about to
  // become the capture bank, and its old mask no longer counts.
  assign wr_sel = cap_sel_q ^ swap;
  assign wr_en  = swap ? in_valid : (in_valid & ~cap_mask);

  assign out_valid = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE) || cap_complete;
  assign state_dbg = state_q;

  // Next-state logic: swap in IDLE, stream numNeurons words, then hold the gap.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    swap         = 1'b0;
    frame_done_d = 1'b0;
    out_data_d   = out_data;
    case (state_q)
      S_IDLE: begin
        if (cap_complete) begin
          swap       = 1'b1;
          state_d    = S_STREAM;
          idx_d      = '0;
          out_data_d = bank_q[cap_sel_q][0];
        end
      end
      S_STREAM: begin
        if (idx_q == LAST_IDX) begin
          state_d      = S_GAP;
          gap_d        = GAP_LOAD;
          frame_done_d = 1'b1;
        end else begin
          idx_d      = idx_q + IW'(1);
          out_data_d = bank_q[~cap_sel_q][idx_d[AW-1:0]];
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers and the registered output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      frame_done <= 1'b0;
      out_data   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      frame_done <= frame_done_d;
      out_data   <= out_data_d;
    end
  end

  // Capture masks, bank selection and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_sel_q <= 1'b0;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      overrun   <= 1'b0;
    end else begin
      if (swap) begin
        cap_sel_q          <= ~cap_sel_q;
        mask_q[~cap_sel_q] <= in_valid;
      end else begin
        mask_q[cap_sel_q] <= cap_mask | in_valid;
        if (|(in_valid & cap_mask)) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Activation storage; a slot is written only while its mask bit is clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeurons; i++) begin
      if (wr_en[i]) begin
        bank_q[wr_sel][i] <= in_data[i*dataWidth +: dataWidth];
      end
    end
  end

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Bench for layer_stream_ctrl: directed scenarios plus randomized frames,
// checked against a frame-level reference model and a burst monitor.
module tb_layer_stream_ctrl;

  localparam int N   = 30;
  localparam int W   = 16;
  localparam int GAP = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N*W-1:0]   in_data = '0;
  logic [N-1:0]     in_valid = '0;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             frame_done;
  logic             busy;
  logic             overrun;
  logic [1:0]       state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  layer_stream_ctrl #(
    .numNeurons (N),
    .dataWidth  (W),
    .gapCycles  (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: frames assembled from first pulses, duplicates flag overrun
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_frame [N];
  bit           m_have  [N];
  bit           exp_ovr;

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < N; i++) m_have[i] = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_apply(input logic [N-1:0] v, input logic [N*W-1:0] d);
    int cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (m_have[i]) exp_ovr = 1'b1;
        else begin
          m_have[i]  = 1'b1;
          m_frame[i] = d[i*W +: W];
        end
      end
    end
    for (int i = 0; i < N; i++) if (m_have[i]) cnt++;
    if (cnt == N) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(m_frame[i]);
        m_have[i] = 1'b0;
      end
    end
  endtask

  // Burst monitor: words, burst lengths, start cycles, low gaps, frame_done
  logic [W-1:0] got_q[$];
  int           len_q[$];
  int           start_q[$];
  int           gap_q[$];
  bit           fd_q[$];
  int           fd_cnt, cur_len, low_run;
  bit           prev_v, seen_burst;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (out_valid) begin
      if (!prev_v) begin
        start_q.push_back(cyc);
        if (seen_burst) gap_q.push_back(low_run);
      end
      got_q.push_back(out_data);
      cur_len++;
    end else if (prev_v) begin
      len_q.push_back(cur_len);
      fd_q.push_back(frame_done);
      cur_len    = 0;
      seen_burst = 1'b1;
      low_run    = 1;
    end else begin
      low_run++;
    end
    prev_v = out_valid;
  end

  task automatic clear_log();
    got_q.delete(); len_q.delete(); start_q.delete(); gap_q.delete(); fd_q.delete();
    fd_cnt = 0; cur_len = 0; low_run = 0; prev_v = 1'b0; seen_burst = 1'b0;
  endtask

  // Driver tasks
  task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    model_apply(v, d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = '0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    clear_log();
  endtask

  task automatic wait_bursts(input int n, input int budget, output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk);
      #1;
      k++;
      if (len_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk);
      #1;
      k++;
      if (start_q.size() >= n) ok = 1'b1;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    #3 rst = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0)     begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    do_reset();
  endtask

  task automatic test_all_at_once();
    logic [N*W-1:0] d;
    int k0, bad;
    bit ok, low_ok;
    do_reset();
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(16'h0100 + i);
    drive_cycle('1, d);
    k0 = cyc;
    drive_cycle('0, '0);
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL all_busy_pending got=%b exp=1", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL all_early_valid got=%b exp=0", out_valid); end
    wait_bursts(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL all_burst_timeout got=0 bursts exp=1"); end
    if (ok) begin
      checks++; if (len_q[0] != N) begin failures++; $display("FAIL all_len got=%0d exp=%0d", len_q[0], N); end
      checks++; if (start_q[0] != k0 + 2) begin failures++; $display("FAIL all_start got=%0d exp=%0d", start_q[0], k0 + 2); end
      bad = 0;
      for (int i = 0; i < N && i < got_q.size(); i++) if (got_q[i] !== W'(16'h0100 + i)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL all_words mismatches=%0d exp=0", bad); end
      checks++; if (fd_q[0] !== 1'b1) begin failures++; $display("FAIL all_fd_align got=%b exp=1", fd_q[0]); end
    end
    low_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) low_ok = 1'b0;
    end
    checks++; if (!low_ok)      begin failures++; $display("FAIL all_low_after got=high exp=low for 3 cycles"); end
    checks++; if (fd_cnt != 1)  begin failures++; $display("FAIL all_fd_count got=%0d exp=1", fd_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL all_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_descending();
    logic [N*W-1:0] d;
    logic [N-1:0] v;
    int k0, bad;
    bit ok;
    do_reset();
    k0 = 0;
    for (int i = N - 1; i >= 0; i--) begin
      v = '0;
      v[i] = 1'b1;
      d = '0;
      d[i*W +: W] = W'($urandom);
      drive_cycle(v, d);
      k0 = cyc;
    end
    drive_cycle('0, '0);
    wait_bursts(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL desc_burst_timeout got=0 bursts exp=1"); end
    if (ok) begin
      checks++; if (start_q[0] != k0 + 2) begin failures++; $display("FAIL desc_start got=%0d exp=%0d", start_q[0], k0 + 2); end
      checks++; if (len_q[0] != N) begin failures++; $display("FAIL desc_len got=%0d exp=%0d", len_q[0], N); end
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL desc_words mismatches=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] da, db;
    int bad;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) begin
      da[i*W +: W] = W'(16'h0100 + i);
      db[i*W +: W] = W'(16'hA000 + i);
    end
    drive_cycle('1, da);
    drive_cycle('0, '0);
    wait_starts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first_timeout got=0 starts exp=1"); end
    repeat ($urandom_range(0, 5)) drive_cycle('0, '0);
    drive_cycle('1, db);
    drive_cycle('0, '0);
    wait_bursts(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_burst_timeout got=%0d bursts exp=2", len_q.size()); end
    if (ok) begin
      checks++; if (len_q[0] != N || len_q[1] != N) begin failures++; $display("FAIL b2b_len got=%0d,%0d exp=%0d", len_q[0], len_q[1], N); end
      checks++; if (gap_q.size() < 1 || gap_q[0] != GAP + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", (gap_q.size() > 0) ? gap_q[0] : -1, GAP + 1); end
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_words mismatches=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun();
    logic [N*W-1:0] d;
    logic [N-1:0] v;
    int bad;
    bit ok;
    do_reset();
    v = '0;
    v[5] = 1'b1;
    d = '0;
    d[5*W +: W] = 16'h1111;
    drive_cycle(v, d);
    d[5*W +: W] = 16'h2222;
    drive_cycle(v, d);
    drive_cycle('0, '0);
    checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL ovr_flag got=%b exp=%b", overrun, exp_ovr); end
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    v = '1;
    v[5] = 1'b0;
    drive_cycle(v, d);
    drive_cycle('0, '0);
    wait_bursts(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_burst_timeout got=0 bursts exp=1"); end
    if (ok) begin
      checks++; if (got_q[5] !== 16'h1111) begin failures++; $display("FAIL ovr_word5 got=%h exp=1111", got_q[5]); end
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL ovr_words mismatches=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); end
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_midburst();
    logic [N*W-1:0] d;
    logic [N-1:0] v;
    int k, bad;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    drive_cycle('1, d);
    drive_cycle('0, '0);
    wait_starts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmb_start_timeout got=0 starts exp=1"); end
    v = '0;
    for (int i = 0; i < 15; i++) begin
      v[i] = 1'b1;
      d[i*W +: W] = W'($urandom);
    end
    drive_cycle(v, d);
    drive_cycle('0, '0);
    k = 0;
    while (got_q.size() < 13 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++; if (got_q.size() != 13) begin failures++; $display("FAIL rmb_index12 got=%0d words exp=13", got_q.size()); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rmb_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rmb_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rmb_frame_done got=%b exp=0", frame_done); end
    do_reset();
    for (int i = 0; i < N; i++) begin
      v = '0;
      v[i] = 1'b1;
      d = '0;
      d[i*W +: W] = W'($urandom);
      drive_cycle(v, d);
    end
    drive_cycle('0, '0);
    wait_bursts(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmb_fresh_timeout got=0 bursts exp=1"); end
    if (ok) begin
      checks++; if (len_q[0] != N) begin failures++; $display("FAIL rmb_fresh_len got=%0d exp=%0d", len_q[0], N); end
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rmb_fresh_words mismatches=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rmb_fresh_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_swap_edge();
    logic [N*W-1:0] da, db;
    logic [N-1:0] v;
    int bad;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) begin
      da[i*W +: W] = W'($urandom);
      db[i*W +: W] = W'($urandom);
    end
    drive_cycle('1, da);
    v = '0;
    v[3] = 1'b1;
    db[3*W +: W] = 16'hB003;
    drive_cycle(v, db);
    drive_cycle('0, '0);
    wait_starts(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL swap_start_timeout got=0 starts exp=1"); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL swap_overrun_early got=%b exp=0", overrun); end
    v = '1;
    v[3] = 1'b0;
    db[3*W +: W] = 16'hDEAD;
    drive_cycle(v, db);
    drive_cycle('0, '0);
    wait_bursts(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL swap_burst_timeout got=%0d bursts exp=2", len_q.size()); end
    if (ok) begin
      checks++; if (got_q[N + 3] !== 16'hB003) begin failures++; $display("FAIL swap_word3 got=%h exp=b003", got_q[N + 3]); end
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL swap_words mismatches=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL swap_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_random();
    logic [N*W-1:0] d;
    logic [N-1:0] v;
    bit done [N];
    int left, bad;
    bit ok;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) done[i] = 1'b0;
      left = N;
      while (left > 0) begin
        v = '0;
        for (int i = 0; i < N; i++) begin
          d[i*W +: W] = W'($urandom);
          if (!done[i] && $urandom_range(0, 3) == 0) begin
            v[i] = 1'b1;
            done[i] = 1'b1;
            left--;
          end else if (done[i] && $urandom_range(0, 40) == 0) begin
            v[i] = 1'b1;
          end
        end
        drive_cycle(v, d);
      end
      drive_cycle('0, '0);
      wait_starts(f + 1, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd_start_timeout frame=%0d got=%0d starts", f, start_q.size()); end
    end
    wait_bursts(4, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rnd_burst_timeout got=%0d bursts exp=4", len_q.size()); end
    bad = 0;
    foreach (len_q[i]) if (len_q[i] != N || fd_q[i] !== 1'b1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_len_fd bad_bursts=%0d exp=0", bad); end
    bad = 0;
    foreach (gap_q[i]) if (gap_q[i] < GAP + 1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_gap short_gaps=%0d exp=0", bad); end
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_words mismatches=%0d got_n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); end
    checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL rnd_overrun got=%b exp=%b", overrun, exp_ovr); end
  endtask

  // Test sequence and final report
  initial begin
    model_clear();
    clear_log();
    test_reset();
    test_all_at_once();
    test_descending();
    test_back_to_back();
    test_overrun();
    test_reset_midburst();
    test_swap_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
